// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment display path.
// Segment patterns are {g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex7seg
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/mux_8.sv
// Generic 8-input multiplexer; ctl = 0 selects in1, ctl = 7 selects in8.
module mux_8 #(
  parameter int DATA_WIDTH = 4
) (
  input  logic [2:0]            ctl,
  input  logic [DATA_WIDTH-1:0] in1,
  input  logic [DATA_WIDTH-1:0] in2,
  input  logic [DATA_WIDTH-1:0] in3,
  input  logic [DATA_WIDTH-1:0] in4,
  input  logic [DATA_WIDTH-1:0] in5,
  input  logic [DATA_WIDTH-1:0] in6,
  input  logic [DATA_WIDTH-1:0] in7,
  input  logic [DATA_WIDTH-1:0] in8,
  output logic [DATA_WIDTH-1:0] out
);

  always_comb begin
    out = in1;
    case (ctl)
      3'd0: out = in1;
      3'd1: out = in2;
      3'd2: out = in3;
      3'd3: out = in4;
      3'd4: out = in5;
      3'd5: out = in6;
      3'd6: out = in7;
      3'd7: out = in8;
      default: out = in1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Eight-digit multiplexed seven-segment driver with a shadow register
// so new values only reach the display at a frame boundary.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [31:0]           data_in,
  input  logic [NUM_DIGITS-1:0] dp_in,
  input  logic [NUM_DIGITS-1:0] digit_en,
  output logic                  upd_pending,
  output logic                  frame_tick,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic [6:0]            seg_n,
  output logic                  dp_n
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PMAX   = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] PGUARD = PW'(GUARD_CYCLES);

  logic [PW-1:0]           pcnt;
  logic [2:0]              dig;
  logic [31:0]             sh_data;
  logic [31:0]             disp_data;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   disp_dp;
  logic                    slot_end;
  logic                    wrap;
  logic                    lit;
  logic [3:0]              nibble;
  logic [6:0]              seg_pat;

  assign slot_end = (pcnt == PMAX);
  assign wrap     = slot_end && (dig == 3'd7);
  assign lit      = (pcnt >= PGUARD) && digit_en[dig];

  mux_8 #(.DATA_WIDTH(4)) u_mux (
    .ctl (dig),
    .in1 (disp_data[3:0]),
    .in2 (disp_data[7:4]),
    .in3 (disp_data[11:8]),
    .in4 (disp_data[15:12]),
    .in5 (disp_data[19:16]),
    .in6 (disp_data[23:20]),
    .in7 (disp_data[27:24]),
    .in8 (disp_data[31:28]),
    .out (nibble)
  );

  hex7seg u_dec (
    .nibble (nibble),
    .seg    (seg_pat)
  );

  // Segments are also blanked during the guard window so a stale pattern
  // never shows while the anodes switch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt        <= '0;
      dig         <= '0;
      sh_data     <= '0;
      sh_dp       <= '0;
      disp_data   <= '0;
      disp_dp     <= '0;
      upd_pending <= 1'b0;
      frame_tick  <= 1'b0;
      an_n        <= '1;
      seg_n       <= SEG_BLANK;
      dp_n        <= 1'b1;
    end else begin
      pcnt       <= slot_end ? '0 : pcnt + 1'b1;
      if (slot_end) dig <= dig + 3'd1;
      frame_tick <= wrap;
      if (wrap && upd_pending) begin
        disp_data <= sh_data;
        disp_dp   <= sh_dp;
      end
      // A load in the commit cycle wins: it keeps the update pending for the next frame.
      if (load) begin
        sh_data     <= data_in;
        sh_dp       <= dp_in;
        upd_pending <= 1'b1;
      end else if (wrap) begin
        upd_pending <= 1'b0;
      end
      an_n  <= lit ? ~(NUM_DIGITS'(1) << dig) : '1;
      seg_n <= lit ? seg_pat : SEG_BLANK;
      dp_n  <= lit ? ~disp_dp[dig] : 1'b1;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: a cycle-count reference model
// queues expected outputs per edge, compared one cycle later.
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [31:0] data_in;
  logic [7:0]  dp_in;
  logic [7:0]  digit_en;
  logic        upd_pending;
  logic        frame_tick;
  logic [7:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       chk_seg;
    logic       ft;
    logic       pend;
  } exp_t;

  exp_t exp_q [$];

  logic [6:0] dec_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  int          t;
  logic [31:0] m_sh, m_disp;
  logic [7:0]  m_shdp, m_dispdp;
  logic        m_pend;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.REFRESH_DIV(8), .GUARD_CYCLES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .data_in     (data_in),
    .dp_in       (dp_in),
    .digit_en    (digit_en),
    .upd_pending (upd_pending),
    .frame_tick  (frame_tick),
    .an_n        (an_n),
    .seg_n       (seg_n),
    .dp_n        (dp_n)
  );

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp)
      $display("[TB] FAIL %s at t=%0d: got %0h, expected %0h", tag, t, act, exp);
    else
      passes++;
  endtask

  task automatic resetModel();
    t = 0; m_sh = '0; m_disp = '0; m_shdp = '0; m_dispdp = '0; m_pend = 1'b0;
  endtask

  // Drive one cycle of inputs, predict the outputs after the next edge, then compare.
  task automatic applyStimulus(input logic ld, input logic [31:0] val,
                               input logic [7:0] dp, input logic [7:0] en);
    int p, d;
    logic lit, wrap;
    logic [3:0] nib;
    exp_t e, got;
    load = ld; data_in = val; dp_in = dp; digit_en = en;
    p    = t % 8;
    d    = (t / 8) % 8;
    lit  = (p >= 2) && en[d];
    wrap = (p == 7) && (d == 7);
    nib  = 4'(m_disp >> (4 * d));
    e.an      = lit ? ~(8'h01 << d) : 8'hFF;
    e.seg     = lit ? dec_tab[nib] : 7'h7F;
    e.dp      = lit ? ~m_dispdp[d] : 1'b1;
    e.chk_seg = lit || !en[d];
    e.ft      = wrap;
    e.pend    = ld ? 1'b1 : (wrap ? 1'b0 : m_pend);
    exp_q.push_back(e);
    if (wrap && m_pend) begin m_disp = m_sh; m_dispdp = m_shdp; end
    if (ld) begin m_sh = val; m_shdp = dp; end
    m_pend = e.pend;
    @(posedge clk);
    #1;
    t++;
    load = 1'b0;
    got = exp_q.pop_front();
    checkOutput("an_n", {24'd0, an_n}, {24'd0, got.an});
    if (got.chk_seg) begin
      checkOutput("seg_n", {25'd0, seg_n}, {25'd0, got.seg});
      checkOutput("dp_n", {31'd0, dp_n}, {31'd0, got.dp});
    end
    checkOutput("frame_tick", {31'd0, frame_tick}, {31'd0, got.ft});
    checkOutput("upd_pending", {31'd0, upd_pending}, {31'd0, got.pend});
  endtask

  task automatic runIdle(input int n, input logic [7:0] en);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'd0, 8'd0, en);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_an_n"}, {24'd0, an_n}, 32'hFF);
    checkOutput({tag, "_seg_n"}, {25'd0, seg_n}, 32'h7F);
    checkOutput({tag, "_dp_n"}, {31'd0, dp_n}, 32'h1);
    checkOutput({tag, "_pending"}, {31'd0, upd_pending}, 32'h0);
    checkOutput({tag, "_frame_tick"}, {31'd0, frame_tick}, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; data_in = '0; dp_in = '0; digit_en = 8'hFF;
    resetModel();
    #12;
    checkResetOutputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Idle scan: zeros on every lit slot, frame tick every 64 cycles.
    runIdle(70, 8'hFF);

    // Single load, observed through at least one full displayed frame.
    applyStimulus(1'b1, 32'h89ABCDEF, 8'h01, 8'hFF);
    runIdle(140, 8'hFF);

    // Two loads inside one frame: only the last is ever shown.
    applyStimulus(1'b1, 32'h11111111, 8'h00, 8'hFF);
    runIdle(5, 8'hFF);
    applyStimulus(1'b1, 32'h22222222, 8'hF0, 8'hFF);
    runIdle(140, 8'hFF);

    // Load landing exactly in the commit cycle.
    applyStimulus(1'b1, 32'h12345678, 8'h0F, 8'hFF);
    while ((t % 64) != 63) applyStimulus(1'b0, 32'd0, 8'd0, 8'hFF);
    applyStimulus(1'b1, 32'h9ABCDEF0, 8'hAA, 8'hFF);
    runIdle(140, 8'hFF);

    // Upper four digits disabled live.
    runIdle(70, 8'h0F);

    // Asynchronous reset mid-slot with a load still pending.
    applyStimulus(1'b1, 32'h55555555, 8'hFF, 8'hFF);
    runIdle(10, 8'hFF);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    resetModel();
    runIdle(140, 8'hFF);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexed driver for the 8-digit seven-segment display. Holds a 32-bit value as eight hex nibbles, scans one digit per refresh slot, selects the active nibble through an internal `mux_8` instance, and decodes it to active-low segment and anode lines. It sits between the system's status/result registers and the board's display pins, and updates tear-free at frame boundaries.

## Interface
- `REFRESH_DIV`, 100000: clock cycles per digit slot (≥ 4).
- `GUARD_CYCLES`, 16: cycles at slot start with all anodes off (anti-ghosting); must be < `REFRESH_DIV`.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `load`  in  1  single-cycle strobe: capture `data_in`/`dp_in`.
- `data_in`  in  32  value; nibble i (`data_in[4i+3:4i]`) goes to digit i, digit 0 rightmost.
- `dp_in`  in  8  decimal point per digit, 1 = lit.
- `digit_en`  in  8  per-digit enable, 0 = blank (sampled live, not shadowed).
- `upd_pending`  out  1  high from `load` until the captured value is on display.
- `frame_tick`  out  1  one-cycle pulse when the scan wraps digit 7 → 0.
- `an_n`  out  8  anode enables, active-low, one-hot-low or all-high.
- `seg_n`  out  7  segments {g,f,e,d,c,b,a}, active-low.
- `dp_n`  out  1  decimal point, active-low.

## Operation
- Registers: prescaler `pcnt` (0..REFRESH_DIV-1), digit counter `dig` (3 bits), shadow `{sh_data, sh_dp}`, display `{disp_data, disp_dp}`, `upd_pending`.
- `pcnt` increments every cycle; at REFRESH_DIV-1 wraps to 0 and `dig` increments (7 → 0 wrap).
- `load`: shadow ← `{data_in, dp_in}`, `upd_pending` ← 1. Later loads before commit overwrite the shadow (last wins).
- Commit: in the cycle `dig`=7 and `pcnt`=REFRESH_DIV-1, if `upd_pending`, display ← shadow, `upd_pending` ← 0; `frame_tick` ← 1 in that same wrap cycle regardless.
- Simultaneous `load` and commit: display takes the old shadow; shadow takes the new value; `upd_pending` stays 1 (commits next frame).
- Nibble path: `mux_8` with `ctl` = `dig`, in1..in8 = `disp_data` nibbles 0..7; result decoded by `hex7seg`.
- Decoder (seg_n): 0→1000000, 1→1111001, 2→0100100, 3→0110000, 4→0011001, 5→0010010, 6→0000010, 7→1111000, 8→0000000, 9→0010000, A→0001000, b→0000011, C→1000110, d→0100001, E→0000110, F→0001110.
- Anode: `an_n[dig]` = 0 only if `pcnt` ≥ GUARD_CYCLES and `digit_en[dig]`=1; all others 1. When a digit is blanked, `seg_n` = 1111111, `dp_n` = 1.
- `dp_n` = ~`disp_dp[dig]`.

## Timing
- Reset values: `pcnt`=0, `dig`=0, shadow/display = 0, `upd_pending`=0, `frame_tick`=0, `an_n`=FF, `seg_n`=7F, `dp_n`=1.
- `an_n`/`seg_n`/`dp_n` registered: reflect `dig`/`pcnt`/display state of the previous cycle (1-cycle latency).
- Slot = REFRESH_DIV cycles; frame = 8·REFRESH_DIV cycles; worst-case load-to-display ≤ 8·REFRESH_DIV + 1 cycles.
- `upd_pending` rises the cycle after `load`; falls the cycle after commit.
- Reset mid-frame: all state returns to reset values immediately (async); pending load discarded.

## Structure
- Shared package `seg7_pkg`: segment-pattern constants for 0–F, blank pattern 7'h7F, `NUM_DIGITS`=8.
- Sub-module `hex7seg` (combinational 4→7 decoder); reuse existing `mux_8` (DATA_WIDTH=4) for nibble select.

## Test plan
(REFRESH_DIV=8, GUARD_CYCLES=2)
- Reset release, no load → `an_n` cycles FE,FD,…,7F with 2 all-high cycles per slot; `seg_n`=1000000 on every lit slot; `frame_tick` every 64 cycles.
- `load` `data_in`=32'h89ABCDEF, `dp_in`=8'h01 → after next frame wrap: digit 0 `seg_n`=0001110 with `dp_n`=0, digit 7 `seg_n`=0000000; `upd_pending` high until commit.
- Two loads (h11111111 then h22222222) within one frame → only h22222222 displayed; no frame shows h11111111.
- `load` in the commit cycle → old shadow displayed this frame, new value next frame, `upd_pending` stays 1 across the wrap.
- `digit_en`=8'h0F → `an_n[7:4]` never low; slots 4–7 show `seg_n`=7F, `dp_n`=1.
- Assert `rst_n`=0 mid-slot with pending load → outputs FF/7F/1 asynchronously; after release display shows 0s, `upd_pending`=0.
